// File: rtl/pulse_emitter.sv
// Turns single-cycle trig requests into clamped-width high pulses, each followed by GAP_LEN forced low cycles.
// Latency: pulse_line rises in the cycle after the sampling edge of a trig that finds the emitter idle.
// Backpressure: none; requests during a pulse queue up to PEND_DEPTH, and further ones are dropped with sticky overflow.
module pulse_emitter #(
    parameter int MIN_LEN    = 3,
    parameter int MAX_LEN    = 15,
    parameter int GAP_LEN    = 2,
    parameter int PEND_DEPTH = 4,
    localparam int LW = $clog2(MAX_LEN + 1),
    localparam int PW = $clog2(PEND_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          trig,
    input  logic [LW-1:0] len_in,
    input  logic          clr_ovf,
    output logic          pulse_line,
    output logic          busy,
    output logic          done,
    output logic [PW-1:0] pend_cnt,
    output logic          overflow
);

    localparam int GW = $clog2(GAP_LEN + 1);
    localparam int CW = (LW > GW) ? LW : GW;
    localparam int AW = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        GAP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [LW-1:0] len_clamped;
    logic [LW-1:0] head_len;
    logic [LW-1:0] start_len;
    logic          ready;
    logic          q_empty;
    logic          q_full;
    logic          start_from_q;
    logic          start_from_trig;
    logic          start;
    logic          push_req;
    logic          q_push;
    logic          q_pop;
    logic          drop;

    logic [LW-1:0] q_mem [PEND_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(PEND_DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        len_clamped = len_in;
        if (len_in < LW'(MIN_LEN)) begin
            len_clamped = LW'(MIN_LEN);
        end else if (len_in > LW'(MAX_LEN)) begin
            len_clamped = LW'(MAX_LEN);
        end
    end

    // A pulse may start when idle or on the final gap cycle; queued requests go before a fresh trig.
    assign ready           = (state_q == IDLE) || ((state_q == GAP) && (cnt_q == '0));
    assign q_empty         = (pend_cnt == '0);
    assign q_full          = (pend_cnt == PW'(PEND_DEPTH));
    assign start_from_q    = ready && !q_empty;
    assign start_from_trig = ready && q_empty && trig;
    assign start           = start_from_q || start_from_trig;
    assign head_len        = q_mem[rd_ptr];
    assign start_len       = start_from_q ? head_len : len_clamped;

    assign push_req = trig && !start_from_trig;
    assign q_pop    = start_from_q;
    assign q_push   = push_req && (!q_full || q_pop);
    assign drop     = push_req && q_full && !q_pop;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = HIGH;
                    cnt_d   = CW'(start_len) - CW'(1);
                end
            end
            HIGH: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = CW'(GAP_LEN - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    if (start) begin
                        state_d = HIGH;
                        cnt_d   = CW'(start_len) - CW'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pulse_line <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pulse_line <= (state_d == HIGH);
            done       <= (state_q == HIGH) && (cnt_q == '0);
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pend_cnt <= '0;
        end else begin
            if (q_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (q_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (q_push && !q_pop) begin
                pend_cnt <= pend_cnt + PW'(1);
            end else if (q_pop && !q_push) begin
                pend_cnt <= pend_cnt - PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (q_push) begin
            q_mem[wr_ptr] <= len_clamped;
        end
    end

    assign busy = (state_q != IDLE) || !q_empty;

endmodule

// File: tb/tb_pulse_emitter.sv
// Directed bench for pulse_emitter: default instance plus a MAX_LEN=10 instance for the upper clamp.
module tb_pulse_emitter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       trig;
    logic [3:0] len_in;
    logic       clr_ovf;
    logic       pulse_line;
    logic       busy;
    logic       done;
    logic [2:0] pend_cnt;
    logic       overflow;

    logic       t2_trig;
    logic [3:0] t2_len;
    logic       t2_clr;
    logic       t2_line;
    logic       t2_busy;
    logic       t2_done;
    logic [2:0] t2_pend;
    logic       t2_ovf;

    int   n_asserts = 0;
    int   n_fail    = 0;
    int   rises;
    int   highs;
    logic prev;

    always #5 clk = ~clk;

    pulse_emitter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .trig       (trig),
        .len_in     (len_in),
        .clr_ovf    (clr_ovf),
        .pulse_line (pulse_line),
        .busy       (busy),
        .done       (done),
        .pend_cnt   (pend_cnt),
        .overflow   (overflow)
    );

    pulse_emitter #(.MAX_LEN(10)) dut_m10 (
        .clk        (clk),
        .rst_n      (rst_n),
        .trig       (t2_trig),
        .len_in     (t2_len),
        .clr_ovf    (t2_clr),
        .pulse_line (t2_line),
        .busy       (t2_busy),
        .done       (t2_done),
        .pend_cnt   (t2_pend),
        .overflow   (t2_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Observation k is the negedge after the k-th posedge following the trig drive.
    task automatic single_pulse(input string tag, input int len, input int exp_l);
        trig   = 1'b1;
        len_in = 4'(len);
        cyc();
        trig = 1'b0;
        for (int k = 1; k <= exp_l + 3; k++) begin
            check({tag, "_line"}, 32'(pulse_line), 32'(k <= exp_l));
            check({tag, "_done"}, 32'(done), 32'(k == exp_l + 1));
            check({tag, "_busy"}, 32'(busy), 32'(k <= exp_l + 2));
            cyc();
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        trig    = 1'b0;
        len_in  = '0;
        clr_ovf = 1'b0;
        t2_trig = 1'b0;
        t2_len  = '0;
        t2_clr  = 1'b0;
        cyc();
        cyc();
        check("rst_line", 32'(pulse_line), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pend", 32'(pend_cnt), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        cyc();

        single_pulse("len5", 5, 5);
        single_pulse("len1", 1, 3);
        single_pulse("len0", 0, 3);
        single_pulse("len15", 15, 15);

        t2_trig = 1'b1;
        t2_len  = 4'd15;
        cyc();
        t2_trig = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            check("m10_line", 32'(t2_line), 32'(k <= 10));
            cyc();
        end

        // Back-to-back: second request queues and starts right after the 2-cycle gap.
        trig   = 1'b1;
        len_in = 4'd4;
        cyc();
        for (int k = 1; k <= 12; k++) begin
            check("b2b_line", 32'(pulse_line), 32'((k <= 4) || (k >= 7 && k <= 9)));
            check("b2b_pend", 32'(pend_cnt), 32'(k >= 3 && k <= 6));
            trig   = (k == 2);
            len_in = 4'd3;
            cyc();
        end

        // Overflow: six requests during a 15-cycle pulse, the fifth and sixth are dropped.
        trig   = 1'b1;
        len_in = 4'd15;
        cyc();
        rises = 0;
        prev  = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (pulse_line && !prev) rises++;
            prev = pulse_line;
            if (k <= 12) begin
                check("ovf_pend", 32'(pend_cnt), (k <= 1) ? 32'd0 : ((k - 1 > 4) ? 32'd4 : 32'(k - 1)));
                check("ovf_flag", 32'(overflow), 32'(k >= 6 && k <= 8));
            end
            trig    = (k >= 1 && k <= 6);
            len_in  = 4'd3;
            clr_ovf = (k == 8);
            cyc();
        end
        check("ovf_pulses", 32'(rises), 32'd5);
        check("ovf_idle", 32'(busy), 32'd0);

        // Full queue: a trig on the queue-start edge pushes while the head pops.
        trig   = 1'b1;
        len_in = 4'd3;
        cyc();
        rises = 0;
        prev  = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (pulse_line && !prev) rises++;
            prev = pulse_line;
            if (k == 5) check("full_pend_pre", 32'(pend_cnt), 32'd4);
            if (k == 6) begin
                check("full_pend_pop", 32'(pend_cnt), 32'd4);
                check("full_ovf", 32'(overflow), 32'd0);
                check("full_line", 32'(pulse_line), 32'd1);
            end
            trig = (k >= 1 && k <= 5);
            cyc();
        end
        check("full_pulses", 32'(rises), 32'd6);
        check("full_idle", 32'(busy), 32'd0);
        check("full_pend_end", 32'(pend_cnt), 32'd0);

        // Reset during the third high cycle of a len-8 pulse with two requests queued.
        trig   = 1'b1;
        len_in = 4'd8;
        cyc();
        len_in = 4'd3;
        cyc();
        cyc();
        trig = 1'b0;
        check("rstm_line_pre", 32'(pulse_line), 32'd1);
        check("rstm_pend_pre", 32'(pend_cnt), 32'd2);
        #1 rst_n = 1'b0;
        #1;
        check("rstm_line", 32'(pulse_line), 32'd0);
        check("rstm_pend", 32'(pend_cnt), 32'd0);
        check("rstm_busy", 32'(busy), 32'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        highs = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (pulse_line) highs++;
        end
        check("rstm_quiet", 32'(highs), 32'd0);
        check("rstm_busy_after", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
